// File: rtl/mips_fetch_pkg.sv
// Shared types for the MIPS fetch stage: FIFO entry layout, fetch FSM states.
package mips_fetch_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {FS_RUN, FS_HALT} fetch_state_t;

endpackage

// File: rtl/mips_fetch_fifo.sv
// Circular FIFO of {pc, instr} entries; flush empties it in one cycle.
module mips_fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction fetch stage: PC, little-endian word assembly, {pc,instr} FIFO,
// redirect/flush. Optional NOP-run halt detector under MIPS_FETCH_NOP_HALT_EN.
//   state   | meaning
//   FS_RUN  | fetching, pushes allowed
//   FS_HALT | NOP run seen; no pushes, FIFO drains, left only by redirect
module mips_fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter int          IMEM_BYTES     = 256,
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int          FIFO_DEPTH     = 2,
    parameter int          NOP_HALT_COUNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  imem [IMEM_BYTES],
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        misalign_err,
    output logic [15:0] fetch_count
);

    localparam int AW = $clog2(IMEM_BYTES);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   pc;
    logic [31:0]   fetch_word;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  wr_data;
    fetch_state_t  state;
    logic          handshake;
    logic          push;
    logic          pop;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [31:0] addr;
        assign addr = pc + 32'(k);
        assign fetch_word[8*k +: 8] = (addr < 32'(IMEM_BYTES)) ? imem[addr[AW-1:0]] : 8'h00;
    end

    assign out_valid = (count != '0);
    assign handshake = out_valid && out_ready;
    // redirect wins: the flush swallows any same-cycle pop or push
    assign pop  = handshake && !redirect_valid;
    assign push = !redirect_valid && (state == FS_RUN)
                  && ((count < CW'(FIFO_DEPTH)) || handshake);

    assign wr_data.pc    = pc;
    assign wr_data.instr = fetch_word;

    mips_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_data),
        .count   (count),
        .head    (head)
    );

    assign out_instr = out_valid ? head.instr : 32'h0;
    assign out_pc    = out_valid ? head.pc    : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
            fetch_count  <= 16'h0;
        end else begin
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
                if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
            end else if (push) begin
                pc <= pc + 32'd4;
            end
            if (pop) fetch_count <= fetch_count + 16'd1;
        end
    end

`ifdef MIPS_FETCH_NOP_HALT_EN
    logic [2:0] nop_count;
    logic [2:0] nop_next;

    assign nop_next = (fetch_word == NOP_WORD) ? nop_count + 3'd1 : 3'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FS_RUN;
            nop_count <= 3'd0;
        end else if (redirect_valid) begin
            state     <= FS_RUN;
            nop_count <= 3'd0;
        end else if (push) begin
            nop_count <= nop_next;
            if (nop_next == 3'(NOP_HALT_COUNT)) state <= FS_HALT;
        end
    end

    assign halted = (state == FS_HALT) && !out_valid;
`else
    assign state  = FS_RUN;
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: vector table, hand sequences, and
// randomized traffic against a queue-based reference model.
module tb_mips_fetch_stage;

    localparam int IMEM_BYTES = 256;
    localparam int DEPTH      = 2;
    localparam int NOP_HALT   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  imem [IMEM_BYTES];
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        misalign_err;
    logic [15:0] fetch_count;

    int tests = 0;
    int fails = 0;

    mips_fetch_stage #(
        .IMEM_BYTES(IMEM_BYTES), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .NOP_HALT_COUNT(NOP_HALT)
    ) dut (
        .clk(clk), .reset(reset), .imem(imem),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_ready(out_ready),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] mq_pc [$];
    logic [31:0] mq_in [$];
    logic [31:0] m_pc;
    bit          m_halt;
    int          m_nops;
    logic [15:0] m_fc;
    bit          m_mis;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] b = a + 32'(k);
            if (b < IMEM_BYTES) w[8*k +: 8] = imem[b[7:0]];
        end
        return w;
    endfunction

    task automatic model_reset();
        mq_pc.delete(); mq_in.delete();
        m_pc = 32'h0; m_halt = 0; m_nops = 0; m_fc = 16'h0; m_mis = 0;
    endtask

    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
        bit popped, can_push;
        logic [31:0] w;
        if (rv) begin
            mq_pc.delete(); mq_in.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (rpc[1:0] != 2'b00) m_mis = 1;
            m_halt = 0; m_nops = 0;
        end else begin
            popped   = (mq_pc.size() != 0) && rdy;
            can_push = !m_halt && ((mq_pc.size() < DEPTH) || popped);
            if (popped) begin
                void'(mq_pc.pop_front()); void'(mq_in.pop_front());
                m_fc = m_fc + 16'd1;
            end
            if (can_push) begin
                w = ref_word(m_pc);
                mq_pc.push_back(m_pc); mq_in.push_back(w);
                m_pc = m_pc + 32'd4;
`ifdef MIPS_FETCH_NOP_HALT_EN
                m_nops = (w == 32'h0) ? m_nops + 1 : 0;
                if (m_nops == NOP_HALT) m_halt = 1;
`endif
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        @(posedge clk);
        model_step(rv, rpc, rdy);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        bit v = (mq_pc.size() != 0);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".pc"},    out_pc,    v ? mq_pc[0] : 32'h0);
        chk({tag, ".instr"}, out_instr, v ? mq_in[0] : 32'h0);
        chk({tag, ".fc"},    32'(fetch_count), 32'(m_fc));
        chk({tag, ".mis"},   32'(misalign_err), 32'(m_mis));
        chk({tag, ".halt"},  32'(halted), 32'(m_halt && !v));
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [15:0] efc;
        logic        emis;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic [15:0] efc, input logic emis);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc; v.efc = efc; v.emis = emis;
        tbl.push_back(v);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [31:0] rpc;
        logic exp_halt_lvl;
        logic exp_valid_lvl;

        for (int b = 0; b < IMEM_BYTES; b++) imem[b] = 8'(b * 7 + 1);
        imem[0] = 8'h0a; imem[1] = 8'h00; imem[2] = 8'h0a; imem[3] = 8'h20;
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;

        // first fetch, backpressure, redirect, misalign, out-of-range
        add(0, 32'h0,  1, 1, 32'h00,  16'd0, 0);
        add(0, 32'h0,  1, 1, 32'h04,  16'd1, 0);
        for (int i = 0; i < 5; i++) add(0, 32'h0, 0, 1, 32'h04, 16'd1, 0);
        add(0, 32'h0,  1, 1, 32'h08,  16'd2, 0);
        add(0, 32'h0,  1, 1, 32'h0C,  16'd3, 0);
        add(1, 32'h14, 1, 0, 32'h00,  16'd3, 0);
        add(0, 32'h0,  0, 1, 32'h14,  16'd3, 0);
        add(1, 32'h17, 0, 0, 32'h00,  16'd3, 1);
        add(0, 32'h0,  1, 1, 32'h14,  16'd3, 1);
        add(1, 32'hFC, 1, 0, 32'h00,  16'd3, 1);
        add(0, 32'h0,  1, 1, 32'hFC,  16'd3, 1);
        add(0, 32'h0,  1, 1, 32'h100, 16'd4, 1);
        add(0, 32'h0,  1, 1, 32'h104, 16'd5, 1);
        add(1, 32'h0,  1, 0, 32'h00,  16'd5, 1);

        repeat (2) @(negedge clk);
        chk("rst.valid", 32'(out_valid), 32'h0);
        chk("rst.pc",    out_pc, 32'h0);
        chk("rst.instr", out_instr, 32'h0);
        chk("rst.halt",  32'(halted), 32'h0);
        chk("rst.mis",   32'(misalign_err), 32'h0);
        chk("rst.fc",    32'(fetch_count), 32'h0);

        reset = 1'b1;
        model_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d.pc", i),    out_pc, tbl[i].epc);
            chk($sformatf("vec%0d.instr", i), out_instr, tbl[i].ev ? ref_word(tbl[i].epc) : 32'h0);
            chk($sformatf("vec%0d.fc", i),    32'(fetch_count), 32'(tbl[i].efc));
            chk($sformatf("vec%0d.mis", i),   32'(misalign_err), 32'(tbl[i].emis));
            chk($sformatf("vec%0d.halt", i),  32'(halted), 32'h0);
        end
        chk("vec.first_instr", ref_word(32'h0), 32'h200A000A);

        // NOP run at 8..23
        for (int b = 8; b < 24; b++) imem[b] = 8'h00;
        repeat (6) cycle(0, 32'h0, 1);
        chk("nop.pc20", out_pc, 32'h14);
        chk("nop.halt_pre", 32'(halted), 32'h0);
        cycle(0, 32'h0, 1);
        chk("nop.fc", 32'(fetch_count), 32'd11);
`ifdef MIPS_FETCH_NOP_HALT_EN
        exp_halt_lvl = 1'b1; exp_valid_lvl = 1'b0;
`else
        exp_halt_lvl = 1'b0; exp_valid_lvl = 1'b1;
`endif
        chk("nop.halted", 32'(halted), 32'(exp_halt_lvl));
        chk("nop.valid",  32'(out_valid), 32'(exp_valid_lvl));
        repeat (3) cycle(0, 32'h0, 1);
        chk("nop.halted_hold", 32'(halted), 32'(exp_halt_lvl));
        chk("nop.valid_hold",  32'(out_valid), 32'(exp_valid_lvl));
        cycle(1, 32'h0, 1);
        chk("nop.redir_halted", 32'(halted), 32'h0);
        chk("nop.redir_valid",  32'(out_valid), 32'h0);
        cycle(0, 32'h0, 1);
        chk("nop.resume_valid", 32'(out_valid), 32'h1);
        chk("nop.resume_pc",    out_pc, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rpc = 32'($urandom_range(0, 68)) * 32'd4;
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(0, 3));
            cycle(($urandom_range(0, 9) == 0), rpc, $urandom_range(0, 1) == 1);
            check_model($sformatf("rnd%0d", i));
        end

        // async reset with two entries buffered
        cycle(1, 32'h40, 0);
        cycle(0, 32'h0, 0);
        cycle(0, 32'h0, 0);
        cycle(0, 32'h0, 0);
        chk("ares.full_pc", out_pc, 32'h40);
        @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("ares.valid", 32'(out_valid), 32'h0);
        chk("ares.fc",    32'(fetch_count), 32'h0);
        chk("ares.mis",   32'(misalign_err), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cycle(0, 32'h0, 0);
        chk("ares.pc",    out_pc, 32'h0);
        chk("ares.instr", out_instr, 32'h200A000A);
        chk("ares.valid2", 32'(out_valid), 32'h1);
        check_model("ares");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
